// File: rtl/gear_pkg.sv
// Shared types and speed thresholds for the gear shift controller.
package gear_pkg;

    typedef logic [1:0] gear_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DWELL,
        FAULT
    } state_t;

    // Upper speed bound (inclusive) of gears 0, 1 and 2; anything above is gear 3.
    localparam logic [3:0] SPD_TH0 = 4'd4;
    localparam logic [3:0] SPD_TH1 = 4'd9;
    localparam logic [3:0] SPD_TH2 = 4'd14;

endpackage

// File: rtl/gear_map.sv
// Combinational speed-to-gear lookup.
module gear_map
    import gear_pkg::*;
(
    input  logic [3:0] i_spd,
    output gear_t      o_gear
);

    always_comb begin
        if (i_spd <= SPD_TH0) begin
            o_gear = gear_t'(0);
        end else if (i_spd <= SPD_TH1) begin
            o_gear = gear_t'(1);
        end else if (i_spd <= SPD_TH2) begin
            o_gear = gear_t'(2);
        end else begin
            o_gear = gear_t'(3);
        end
    end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear shift controller: target capture, one-step req/ack shifting, dwell and timeout fault.
// Optional downshift hysteresis is enabled by defining GEAR_HYST_EN.
module gear_shift_ctrl
    import gear_pkg::*;
#(
    parameter int DWELL_CYC = 8,
    parameter int SHIFT_TO  = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spd_vld,
    input  logic [3:0] i_spd,
    input  logic       i_shift_ack,
    input  logic       i_clr_fault,
    output logic       o_shift_req,
    output logic       o_shift_dir,
    output logic [1:0] o_gear,
    output logic       o_busy,
    output logic       o_fault
);

    localparam int DW_W = $clog2(DWELL_CYC + 1);
    localparam int TO_W = $clog2(SHIFT_TO + 1);

    state_t            r_state;
    gear_t             r_gear;
    gear_t             r_tgt;
    logic              r_shift_req;
    logic              r_shift_dir;
    logic              r_busy;
    logic              r_fault;
    logic [DW_W-1:0]   r_dwell_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    gear_t             w_map_spd;
    gear_t             w_tgt_next;

    gear_map u_map_spd (
        .i_spd  (i_spd),
        .o_gear (w_map_spd)
    );

`ifdef GEAR_HYST_EN
    logic [3:0] w_spd_inc;
    gear_t      w_map_inc;

    // Saturate so spd=15 does not wrap to 0 when probing the next speed up.
    assign w_spd_inc = (i_spd == 4'hF) ? 4'hF : i_spd + 4'd1;

    gear_map u_map_inc (
        .i_spd  (w_spd_inc),
        .o_gear (w_map_inc)
    );

    assign w_tgt_next = (w_map_spd < r_gear) ? w_map_inc : w_map_spd;
`else
    assign w_tgt_next = w_map_spd;
`endif

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_gear      <= gear_t'(0);
            r_tgt       <= gear_t'(0);
            r_shift_req <= 1'b0;
            r_shift_dir <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
            r_dwell_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            if (i_spd_vld) begin
                r_tgt <= w_tgt_next;
            end

            case (r_state)
                IDLE: begin
                    if (r_tgt != r_gear) begin
                        r_state     <= SHIFT;
                        r_shift_req <= 1'b1;
                        r_shift_dir <= (r_tgt > r_gear);
                        r_busy      <= 1'b1;
                        r_to_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (i_shift_ack) begin
                        r_gear      <= r_shift_dir ? r_gear + 2'd1 : r_gear - 2'd1;
                        r_shift_req <= 1'b0;
                        r_dwell_cnt <= DW_W'(DWELL_CYC - 1);
                        r_state     <= DWELL;
                    end else if (r_to_cnt == TO_W'(SHIFT_TO - 1)) begin
                        r_shift_req <= 1'b0;
                        r_fault     <= 1'b1;
                        r_state     <= FAULT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                DWELL: begin
                    if (r_dwell_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt - DW_W'(1);
                    end
                end
                FAULT: begin
                    if (i_clr_fault) begin
                        r_fault <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_shift_req = r_shift_req;
    assign o_shift_dir = r_shift_dir;
    assign o_gear      = r_gear;
    assign o_busy      = r_busy;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Self-checking bench for gear_shift_ctrl: timestamp-based reference model plus directed
// and randomized stimulus. Follows GEAR_HYST_EN the same way the design does.
module tb_gear_shift_ctrl;

    localparam int DWELL_CYC = 8;
    localparam int SHIFT_TO  = 15;

    logic       clk;
    logic       i_rst;
    logic       i_spd_vld;
    logic [3:0] i_spd;
    logic       i_shift_ack;
    logic       i_clr_fault;
    logic       o_shift_req;
    logic       o_shift_dir;
    logic [1:0] o_gear;
    logic       o_busy;
    logic       o_fault;

    int n_checks = 0;
    int n_pass   = 0;

    gear_shift_ctrl #(
        .DWELL_CYC (DWELL_CYC),
        .SHIFT_TO  (SHIFT_TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_spd_vld   (i_spd_vld),
        .i_spd       (i_spd),
        .i_shift_ack (i_shift_ack),
        .i_clr_fault (i_clr_fault),
        .o_shift_req (o_shift_req),
        .o_shift_dir (o_shift_dir),
        .o_gear      (o_gear),
        .o_busy      (o_busy),
        .o_fault     (o_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: gears are spd/5; shifting is described by edge timestamps
    // (when the request rose, when the dwell after the last shift ends).
    int     m_gear, m_tgt;
    bit     m_req, m_dir, m_fault;
    longint m_t_req, m_dwell_done;

    function automatic int target_of(input int spd, input int cur_gear);
        int g;
        g = spd / 5;
`ifdef GEAR_HYST_EN
        if (g < cur_gear) g = ((spd + 1 > 15) ? 15 : spd + 1) / 5;
`endif
        return g;
    endfunction

    task automatic model_step(input longint n);
        int new_tgt;
        if (i_rst) begin
            m_gear = 0; m_tgt = 0; m_req = 0; m_dir = 0; m_fault = 0;
            m_dwell_done = n;
        end else begin
            new_tgt = i_spd_vld ? target_of(int'(i_spd), m_gear) : m_tgt;
            if (m_req) begin
                if (i_shift_ack) begin
                    m_gear       = m_dir ? m_gear + 1 : m_gear - 1;
                    m_req        = 0;
                    m_dwell_done = n + DWELL_CYC;
                end else if (n - m_t_req == SHIFT_TO) begin
                    m_req   = 0;
                    m_fault = 1;
                end
            end else if (m_fault) begin
                if (i_clr_fault) begin
                    m_fault      = 0;
                    m_dwell_done = n;
                end
            end else if (n > m_dwell_done && m_tgt != m_gear) begin
                m_req   = 1;
                m_dir   = (m_tgt > m_gear);
                m_t_req = n;
            end
            m_tgt = new_tgt;
        end
    endtask

    initial begin
        longint n = 0;
        m_dwell_done = -100;
        forever begin
            @(posedge clk);
            #1;
            model_step(n);
            check("gear", o_gear, m_gear);
            check("shift_req", o_shift_req, m_req);
            if (m_req) check("shift_dir", o_shift_dir, m_dir);
            check("busy", o_busy, (m_req || m_fault || n < m_dwell_done) ? 1 : 0);
            check("fault", o_fault, m_fault);
            n++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic spd_in(input int s);
        i_spd     = 4'(s);
        i_spd_vld = 1'b1;
        tick(1);
        i_spd_vld = 1'b0;
    endtask

    task automatic auto_ack(input int cycles, output int acks, output int min_gap);
        int last = -1000;
        acks    = 0;
        min_gap = 1000;
        for (int i = 0; i < cycles; i++) begin
            if (o_shift_req && !i_shift_ack) begin
                i_shift_ack = 1'b1;
                if (acks > 0 && i - last < min_gap) min_gap = i - last;
                last = i;
                acks++;
            end else begin
                i_shift_ack = 1'b0;
            end
            tick(1);
        end
        i_shift_ack = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (o_busy && c < 100) begin
            tick(1);
            c++;
        end
        check("wait_idle_bound", (c < 100) ? 1 : 0, 1);
    endtask

    initial begin
        int c, acks, gap, p;
        i_rst = 1'b1; i_spd_vld = 1'b0; i_spd = 4'd0; i_shift_ack = 1'b0; i_clr_fault = 1'b0;
        @(negedge clk);

        // 1: reset held two cycles, then quiet
        tick(2);
        check("rst_gear", o_gear, 0);
        check("rst_req", o_shift_req, 0);
        check("rst_busy", o_busy, 0);
        check("rst_fault", o_fault, 0);
        i_rst = 1'b0;
        tick(4);
        check("idle_no_req", o_shift_req, 0);

        // 2: single upshift, ack three cycles after the request, full dwell
        spd_in(7);
        check("t2_req_latency", o_shift_req, 0);
        tick(1);
        check("t2_req", o_shift_req, 1);
        check("t2_dir", o_shift_dir, 1);
        tick(2);
        i_shift_ack = 1'b1;
        tick(1);
        i_shift_ack = 1'b0;
        check("t2_gear", o_gear, 1);
        check("t2_req_drop", o_shift_req, 0);
        c = 0;
        while (o_busy && c < 40) begin
            c++;
            tick(1);
        end
        check("t2_dwell_cycles", c, DWELL_CYC);

        // 3: 1 -> 3 requires single steps separated by dwell
        spd_in(15);
        auto_ack(60, acks, gap);
        check("t3_acks", acks, 2);
        check("t3_gap_ge_dwell", (gap >= DWELL_CYC) ? 1 : 0, 1);
        check("t3_gear", o_gear, 3);
        wait_idle();

        // 4: reach gear 2, then never ack a downshift -> timeout fault
        spd_in(12);
        auto_ack(30, acks, gap);
        check("t4_gear2", o_gear, 2);
        wait_idle();
        spd_in(2);
        c = 0;
        while (!o_shift_req && c < 5) begin
            tick(1);
            c++;
        end
        c = 0;
        while (o_shift_req && c < 40) begin
            c++;
            tick(1);
        end
        check("t4_req_cycles", c, SHIFT_TO);
        check("t4_fault", o_fault, 1);
        check("t4_gear_held", o_gear, 2);
        i_clr_fault = 1'b1;
        tick(1);
        i_clr_fault = 1'b0;
        check("t4_fault_clr", o_fault, 0);
        check("t4_busy_clr", o_busy, 0);
        tick(1);
        check("t4_new_req", o_shift_req, 1);
        check("t4_new_dir", o_shift_dir, 0);
        auto_ack(40, acks, gap);
        check("t4_gear0", o_gear, 0);
        wait_idle();

        // 5: gear 1, speed 4 -> hysteresis decides
        spd_in(7);
        auto_ack(30, acks, gap);
        wait_idle();
        check("t5_gear1", o_gear, 1);
        spd_in(4);
        auto_ack(30, acks, gap);
`ifdef GEAR_HYST_EN
        check("t5_hyst_acks", acks, 0);
        check("t5_hyst_gear", o_gear, 1);
`else
        check("t5_acks", acks, 1);
        check("t5_gear", o_gear, 0);
`endif
        wait_idle();

        // 6: reset during an outstanding request, late ack ignored
        spd_in(15);
        tick(1);
        check("t6_req", o_shift_req, 1);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        check("t6_req_rst", o_shift_req, 0);
        check("t6_gear_rst", o_gear, 0);
        i_shift_ack = 1'b1;
        tick(1);
        i_shift_ack = 1'b0;
        tick(2);
        check("t6_late_ack_gear", o_gear, 0);
        check("t6_late_ack_req", o_shift_req, 0);

        // Randomized phase: segments with different actuator responsiveness
        for (int seg = 0; seg < 10; seg++) begin
            case ($urandom_range(0, 2))
                0:       p = 3;
                1:       p = 30;
                default: p = 90;
            endcase
            for (int i = 0; i < 300; i++) begin
                i_rst       = ($urandom_range(0, 299) == 0);
                i_spd_vld   = ($urandom_range(0, 3) == 0);
                i_spd       = 4'($urandom_range(0, 15));
                i_shift_ack = ($urandom_range(0, 99) < p);
                i_clr_fault = ($urandom_range(0, 7) == 0);
                tick(1);
            end
        end
        i_rst = 1'b0; i_spd_vld = 1'b0; i_shift_ack = 1'b0; i_clr_fault = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
